// File: rtl/ex_pkg.sv
// Shared widths, opcodes, FSM state type and write-enable decode for the execute stage.
package ex_pkg;

  localparam int unsigned EX_DATA_W = 8;
  localparam int unsigned EX_ADDR_W = 3;
  localparam int unsigned EX_OP_W   = 4;

  localparam logic [EX_OP_W-1:0] OP_NOP  = 4'h0;
  localparam logic [EX_OP_W-1:0] OP_ADD  = 4'h1;
  localparam logic [EX_OP_W-1:0] OP_SUB  = 4'h2;
  localparam logic [EX_OP_W-1:0] OP_AND  = 4'h3;
  localparam logic [EX_OP_W-1:0] OP_OR   = 4'h4;
  localparam logic [EX_OP_W-1:0] OP_XOR  = 4'h5;
  localparam logic [EX_OP_W-1:0] OP_SLL  = 4'h6;
  localparam logic [EX_OP_W-1:0] OP_SRL  = 4'h7;
  localparam logic [EX_OP_W-1:0] OP_MOV  = 4'h8;
  localparam logic [EX_OP_W-1:0] OP_SLT  = 4'h9;
  localparam logic [EX_OP_W-1:0] OP_SEQ  = 4'hA;
  localparam logic [EX_OP_W-1:0] OP_ADDC = 4'hB;
  localparam logic [EX_OP_W-1:0] OP_MUL  = 4'hC;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MULT = 1'b1
  } state_t;

  typedef struct packed {
    logic reg_wr;
    logic cb_wr;
  } wr_ctl_t;

  // Which regfile ports an opcode eventually writes.
  function automatic wr_ctl_t decode_writes(input logic [EX_OP_W-1:0] op);
    wr_ctl_t w;
    w = '0;
    case (op)
      OP_ADD, OP_SUB, OP_ADDC, OP_MUL: begin
        w.reg_wr = 1'b1;
        w.cb_wr  = 1'b1;
      end
      OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_MOV: w.reg_wr = 1'b1;
      OP_SLT, OP_SEQ: w.cb_wr = 1'b1;
      default: ;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/ex_mul_seq.sv
// Iterative shift-add multiplier: one partial product per clock, W iterations after start.
// done_c/product_c are combinational so the caller can register the final product on the last edge.
module ex_mul_seq #(
  parameter int unsigned W = 8
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           start_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           done_c,
  output logic [2*W-1:0] product_c
);

  localparam int unsigned CNT_W = $clog2(W);

  logic             run_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2*W-1:0]   mcand_q;
  logic [2*W-1:0]   acc_q;
  logic [W-1:0]     mplier_q;
  logic [2*W-1:0]   acc_d;

  always_comb begin
    acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  assign product_c = acc_d;
  assign done_c    = run_q && (cnt_q == CNT_W'(W - 1));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
    end else if (start_i) begin
      run_q    <= 1'b1;
      cnt_q    <= '0;
      mcand_q  <= {{W{1'b0}}, a_i};
      acc_q    <= '0;
      mplier_q <= b_i;
    end else if (run_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_W'(1);
      if (done_c) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU feeding the regfile write/CB ports.
// Define EX_STAGE_MUL_EN to add the multi-cycle MUL (opcode C); otherwise opcode C is a NOP.
module ex_stage
  import ex_pkg::*;
#(
  parameter int unsigned DATA_W = EX_DATA_W,
  parameter int unsigned ADDR_W = EX_ADDR_W,
  parameter int unsigned OP_W   = EX_OP_W
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [OP_W-1:0]   op_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [ADDR_W-1:0] dest_addr_i,
  input  logic              cb_i,
  output logic              wb_write_o,
  output logic [ADDR_W-1:0] wb_addr_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              wb_write_cb_o,
  output logic              wb_cb_data_o,
  output logic              busy_o
);

  state_t            state_q, state_d;
  logic              ready_d;
  logic              wb_write_d;
  logic              wb_write_cb_d;
  logic              wb_cb_data_d;
  logic [ADDR_W-1:0] wb_addr_d;
  logic [DATA_W-1:0] wb_data_d;
  logic              accept_c;
  wr_ctl_t           wr_ctl_c;
  logic [DATA_W:0]   sum_c;
  logic [DATA_W:0]   diff_c;
  logic [DATA_W-1:0] alu_data_c;
  logic              alu_cb_c;

  assign accept_c = valid_i & ready_o;
  assign wr_ctl_c = decode_writes(op_i);

`ifdef EX_STAGE_MUL_EN
  logic              mul_start_c;
  logic              mul_done_c;
  logic [2*DATA_W-1:0] mul_prod_c;
  logic [ADDR_W-1:0] dest_q;

  ex_mul_seq #(.W(DATA_W)) u_mul (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .start_i   (mul_start_c),
    .a_i       (rs_data_i),
    .b_i       (rt_data_i),
    .done_c    (mul_done_c),
    .product_c (mul_prod_c)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      dest_q <= '0;
      busy_o <= 1'b0;
    end else begin
      if (mul_start_c) dest_q <= dest_addr_i;
      busy_o <= (state_d == MULT);
    end
  end
`else
  assign busy_o = 1'b0;
`endif

  // Single-cycle ALU; carry/borrow come from the 9-bit intermediate.
  always_comb begin
    sum_c      = {1'b0, rs_data_i} + {1'b0, rt_data_i} + {{DATA_W{1'b0}}, (op_i == OP_ADDC) & cb_i};
    diff_c     = {1'b0, rs_data_i} - {1'b0, rt_data_i};
    alu_data_c = '0;
    alu_cb_c   = 1'b0;
    case (op_i)
      OP_ADD, OP_ADDC: begin
        alu_data_c = sum_c[DATA_W-1:0];
        alu_cb_c   = sum_c[DATA_W];
      end
      OP_SUB: begin
        alu_data_c = diff_c[DATA_W-1:0];
        alu_cb_c   = diff_c[DATA_W];
      end
      OP_AND: alu_data_c = rs_data_i & rt_data_i;
      OP_OR:  alu_data_c = rs_data_i | rt_data_i;
      OP_XOR: alu_data_c = rs_data_i ^ rt_data_i;
      OP_SLL: alu_data_c = rs_data_i << rt_data_i[2:0];
      OP_SRL: alu_data_c = rs_data_i >> rt_data_i[2:0];
      OP_MOV: alu_data_c = rs_data_i;
      OP_SLT: alu_cb_c   = (rs_data_i < rt_data_i);
      OP_SEQ: alu_cb_c   = (rs_data_i == rt_data_i);
      default: ;
    endcase
  end

  // Next state and next values of every registered output; data/addr/CB hold unless written.
  always_comb begin
    state_d       = state_q;
    ready_d       = 1'b1;
    wb_write_d    = 1'b0;
    wb_write_cb_d = 1'b0;
    wb_addr_d     = wb_addr_o;
    wb_data_d     = wb_data_o;
    wb_cb_data_d  = wb_cb_data_o;
`ifdef EX_STAGE_MUL_EN
    mul_start_c   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (accept_c) begin
`ifdef EX_STAGE_MUL_EN
          if (op_i == OP_MUL) begin
            state_d     = MULT;
            ready_d     = 1'b0;
            mul_start_c = 1'b1;
          end
`endif
          if (op_i != OP_MUL) begin
            if (wr_ctl_c.reg_wr) begin
              wb_write_d = 1'b1;
              wb_addr_d  = dest_addr_i;
              wb_data_d  = alu_data_c;
            end
            if (wr_ctl_c.cb_wr) begin
              wb_write_cb_d = 1'b1;
              wb_cb_data_d  = alu_cb_c;
            end
          end
        end
      end
`ifdef EX_STAGE_MUL_EN
      MULT: begin
        ready_d = 1'b0;
        if (mul_done_c) begin
          state_d       = IDLE;
          ready_d       = 1'b1;
          wb_write_d    = 1'b1;
          wb_write_cb_d = 1'b1;
          wb_addr_d     = dest_q;
          wb_data_d     = mul_prod_c[DATA_W-1:0];
          wb_cb_data_d  = |mul_prod_c[2*DATA_W-1:DATA_W];
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      ready_o       <= 1'b1;
      wb_write_o    <= 1'b0;
      wb_write_cb_o <= 1'b0;
      wb_addr_o     <= '0;
      wb_data_o     <= '0;
      wb_cb_data_o  <= 1'b0;
    end else begin
      state_q       <= state_d;
      ready_o       <= ready_d;
      wb_write_o    <= wb_write_d;
      wb_write_cb_o <= wb_write_cb_d;
      wb_addr_o     <= wb_addr_d;
      wb_data_o     <= wb_data_d;
      wb_cb_data_o  <= wb_cb_data_d;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vector table, MUL/reset sequences, and a
// randomized run against a behavioural model (MUL expectations follow EX_STAGE_MUL_EN).
module tb_ex_stage;

`ifdef EX_STAGE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       valid_i;
  logic       ready_o;
  logic [3:0] op_i;
  logic [7:0] rs_data_i;
  logic [7:0] rt_data_i;
  logic [2:0] dest_addr_i;
  logic       cb_i;
  logic       wb_write_o;
  logic [2:0] wb_addr_o;
  logic [7:0] wb_data_o;
  logic       wb_write_cb_o;
  logic       wb_cb_data_o;
  logic       busy_o;

  ex_stage dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .op_i          (op_i),
    .rs_data_i     (rs_data_i),
    .rt_data_i     (rt_data_i),
    .dest_addr_i   (dest_addr_i),
    .cb_i          (cb_i),
    .wb_write_o    (wb_write_o),
    .wb_addr_o     (wb_addr_o),
    .wb_data_o     (wb_data_o),
    .wb_write_cb_o (wb_write_cb_o),
    .wb_cb_data_o  (wb_cb_data_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  logic [2:0] exp_addr;
  logic [7:0] exp_data;
  logic       exp_cb;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] d;
    logic       cb;
    logic       wr;
    logic       wcb;
    logic [7:0] data;
    logic       cbo;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string nm, input bit wr, input bit wcb, input bit rdy, input bit bsy);
    chk({nm, ".wr"},    32'(wb_write_o),    32'(wr));
    chk({nm, ".wcb"},   32'(wb_write_cb_o), 32'(wcb));
    chk({nm, ".ready"}, 32'(ready_o),       32'(rdy));
    chk({nm, ".busy"},  32'(busy_o),        32'(bsy));
    chk({nm, ".addr"},  32'(wb_addr_o),     32'(exp_addr));
    chk({nm, ".data"},  32'(wb_data_o),     32'(exp_data));
    chk({nm, ".cb"},    32'(wb_cb_data_o),  32'(exp_cb));
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] d, input logic c);
    valid_i     = 1'b1;
    op_i        = op;
    rs_data_i   = a;
    rt_data_i   = b;
    dest_addr_i = d;
    cb_i        = c;
  endtask

  // Behavioural reference for the single-cycle opcodes, from plain integer arithmetic.
  task automatic ref_alu(input int op, input int a, input int b, input int c,
                         output bit wr, output bit wcb, output int data, output int cbo);
    int r;
    wr = 0; wcb = 0; data = 0; cbo = 0;
    case (op)
      1:  begin r = a + b;     wr = 1; wcb = 1; data = r % 256; cbo = int'(r > 255); end
      2:  begin r = a - b;     wr = 1; wcb = 1; data = (r + 256) % 256; cbo = int'(a < b); end
      3:  begin wr = 1; data = a & b; end
      4:  begin wr = 1; data = a | b; end
      5:  begin wr = 1; data = a ^ b; end
      6:  begin wr = 1; data = (a << (b % 8)) % 256; end
      7:  begin wr = 1; data = a >> (b % 8); end
      8:  begin wr = 1; data = a; end
      9:  begin wcb = 1; cbo = int'(a < b); end
      10: begin wcb = 1; cbo = int'(a == b); end
      11: begin r = a + b + c; wr = 1; wcb = 1; data = r % 256; cbo = int'(r > 255); end
      default: ;
    endcase
  endtask

  initial begin
    bit   e_wr, e_wcb, m_ready, accepted;
    int   left, p_a, p_b, p_d, r, md, mc;

    vecs[0]  = '{4'h1, 8'hF0, 8'h20, 3'd3, 1'b0, 1'b1, 1'b1, 8'h10, 1'b1};
    vecs[1]  = '{4'h2, 8'h05, 8'h07, 3'd1, 1'b0, 1'b1, 1'b1, 8'hFE, 1'b1};
    vecs[2]  = '{4'h2, 8'h07, 8'h05, 3'd2, 1'b0, 1'b1, 1'b1, 8'h02, 1'b0};
    vecs[3]  = '{4'h3, 8'hCC, 8'h0F, 3'd4, 1'b1, 1'b1, 1'b0, 8'h0C, 1'b0};
    vecs[4]  = '{4'h4, 8'hA0, 8'h05, 3'd5, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0};
    vecs[5]  = '{4'h5, 8'hFF, 8'h0F, 3'd6, 1'b0, 1'b1, 1'b0, 8'hF0, 1'b0};
    vecs[6]  = '{4'h6, 8'h81, 8'h0B, 3'd7, 1'b0, 1'b1, 1'b0, 8'h08, 1'b0};
    vecs[7]  = '{4'h7, 8'h81, 8'h0F, 3'd0, 1'b0, 1'b1, 1'b0, 8'h01, 1'b0};
    vecs[8]  = '{4'h8, 8'h5A, 8'h33, 3'd1, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0};
    vecs[9]  = '{4'h9, 8'h05, 8'h07, 3'd2, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1};
    vecs[10] = '{4'hA, 8'h07, 8'h07, 3'd3, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1};
    vecs[11] = '{4'hA, 8'h07, 8'h08, 3'd3, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0};
    vecs[12] = '{4'hB, 8'hFF, 8'h00, 3'd4, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1};
    vecs[13] = '{4'hB, 8'h10, 8'h20, 3'd5, 1'b1, 1'b1, 1'b1, 8'h31, 1'b0};
    vecs[14] = '{4'h0, 8'h11, 8'h22, 3'd6, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[15] = '{4'hE, 8'h11, 8'h22, 3'd6, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[16] = '{4'hF, 8'h33, 8'h44, 3'd7, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};

    reset_i = 1'b1;
    valid_i = 1'b0; op_i = '0; rs_data_i = '0; rt_data_i = '0; dest_addr_i = '0; cb_i = 1'b0;
    exp_addr = '0; exp_data = '0; exp_cb = 1'b0;
    repeat (2) tick();
    check_all("reset", 0, 0, 1, 0);
    @(negedge clk_i);
    reset_i = 1'b0;

    // Directed single-cycle vectors, issued back to back.
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].cb);
      tick();
      if (vecs[i].wr) begin
        exp_addr = vecs[i].d;
        exp_data = vecs[i].data;
      end
      if (vecs[i].wcb) exp_cb = vecs[i].cbo;
      check_all($sformatf("vec%0d", i), vecs[i].wr, vecs[i].wcb, 1, 0);
    end
    valid_i = 1'b0;
    tick();
    check_all("idle", 0, 0, 1, 0);

    // Randomized traffic against the model; a stalled op is held until accepted.
    left = 0; p_a = 0; p_b = 0; p_d = 0; m_ready = 1'b1;
    for (int cyc = 0; cyc < 400 || left > 0; cyc++) begin
      if (cyc >= 400) valid_i = 1'b0;
      else if (!(valid_i && !m_ready)) begin
        valid_i     = ($urandom_range(0, 3) != 0);
        op_i        = 4'($urandom_range(0, 15));
        rs_data_i   = 8'($urandom);
        rt_data_i   = 8'($urandom);
        dest_addr_i = 3'($urandom);
        cb_i        = 1'($urandom);
      end
      accepted = valid_i && m_ready;
      e_wr = 0; e_wcb = 0;
      if (left > 0) begin
        left--;
        if (left == 0) begin
          r = p_a * p_b;
          e_wr = 1; e_wcb = 1;
          exp_addr = 3'(p_d);
          exp_data = 8'(r % 256);
          exp_cb   = (r > 255);
        end
      end else if (accepted) begin
        if (op_i == 4'hC && MUL_EN) begin
          left = 8; p_a = int'(rs_data_i); p_b = int'(rt_data_i); p_d = int'(dest_addr_i);
        end else begin
          ref_alu(int'(op_i), int'(rs_data_i), int'(rt_data_i), int'(cb_i), e_wr, e_wcb, md, mc);
          if (e_wr) begin
            exp_addr = dest_addr_i;
            exp_data = 8'(md);
          end
          if (e_wcb) exp_cb = 1'(mc);
        end
      end
      m_ready = (left == 0);
      tick();
      check_all("rnd", e_wr, e_wcb, m_ready, left > 0);
      if (left > 0) begin
        rs_data_i = 8'($urandom);
        rt_data_i = 8'($urandom);
      end
    end
    valid_i = 1'b0;

`ifdef EX_STAGE_MUL_EN
    // MUL 0x13*0x11 with an ADD held on the issue port throughout.
    drive(4'hC, 8'h13, 8'h11, 3'd5, 1'b0);
    tick();
    drive(4'h1, 8'h01, 8'h02, 3'd6, 1'b0);
    check_all("mul_wait0", 0, 0, 0, 1);
    for (int k = 1; k < 8; k++) begin
      tick();
      check_all($sformatf("mul_wait%0d", k), 0, 0, 0, 1);
    end
    tick();
    exp_addr = 3'd5; exp_data = 8'h43; exp_cb = 1'b1;
    check_all("mul_done", 1, 1, 1, 0);
    tick();
    exp_addr = 3'd6; exp_data = 8'h03; exp_cb = 1'b0;
    check_all("add_after_mul", 1, 1, 1, 0);
    valid_i = 1'b0;

    drive(4'hC, 8'h13, 8'h11, 3'd2, 1'b0);
    tick();
    valid_i = 1'b0;
    repeat (3) tick();
`else
    drive(4'hC, 8'h02, 8'h03, 3'd1, 1'b1);
    tick();
    check_all("mul_off", 0, 0, 1, 0);
    valid_i = 1'b0;
    tick();
    check_all("mul_off_idle", 0, 0, 1, 0);
`endif

    // Asynchronous reset (mid-multiply when MUL is built in) clears everything at once.
    reset_i = 1'b1;
    #1;
    exp_addr = '0; exp_data = '0; exp_cb = 1'b0;
    check_all("rst_mid", 0, 0, 1, 0);
    @(negedge clk_i);
    reset_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check_all("post_rst", 0, 0, 1, 0);
    end
    drive(4'h3, 8'hCC, 8'h0F, 3'd4, 1'b0);
    tick();
    exp_addr = 3'd4; exp_data = 8'h0C;
    check_all("and_after_rst", 1, 0, 1, 0);
    valid_i = 1'b0;
    tick();
    check_all("final_idle", 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
